probe_capture_ctrl: RTL and testbench

- Trigger sequencer and capture buffer for wide debug probe vectors, for example a {probe10,probe11,probe12}-style bus.
- Arms on command, keeps a circular pre-trigger history, and detects a masked-compare trigger.
- After the trigger, fills the remaining buffer depth, then streams the full capture out in time order over a valid/ready port.
- Sits beside the on-chip watcher so that the probe bundles can be captured by fabric logic (e.g. forwarded over UDP) without the vendor tool.

---
 rtl/probe_capture_if.sv | 15 +
 rtl/probe_capture_ctrl.sv | 158 +++++++++++++++
 tb/tb_probe_capture_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/probe_capture_if.sv
// Readout stream bundle for probe_capture_ctrl.
// Ports (modports):
//   master : drives rd_data, rd_valid, rd_last; samples rd_ready
//   slave  : samples rd_data, rd_valid, rd_last; drives rd_ready
interface probe_capture_if #(
  parameter int DATA_W = 96
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/probe_capture_ctrl.sv
// Trigger sequencer and capture buffer for wide debug probe vectors.
// Arms on command and keeps a circular pre-trigger history. Triggers on a
// masked compare, fills the rest of the buffer, then streams all DEPTH
// samples out in time order.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   arm, abort      start pulse (IDLE only) / return to IDLE from anywhere
//   pre_cnt         pre-trigger sample count, latched on arm
//   trig_mask/value masked-compare trigger, latched on arm
//   probe           sampled every cycle while capturing
//   busy, triggered status flags
//   done            one-cycle pulse after the final readout handshake
//   rd              readout stream (rd_data/rd_valid/rd_ready/rd_last)
//
// state  | meaning
// IDLE   | waiting for arm
// PRE    | writing pre_cnt history samples, trigger ignored
// ARMED  | writing circularly, looking for a trigger hit
// POST   | writing the remaining DEPTH-1-pre_cnt samples
// READ   | streaming DEPTH samples from (trig_addr - pre_cnt)
module probe_capture_ctrl #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_cnt,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] probe,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  probe_capture_if.master   rd
);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READ} state_t;

  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] pre_l;
  logic [DATA_W-1:0] mask_l;
  logic [DATA_W-1:0] value_l;
  logic [ADDR_W-1:0] pre_rem;
  logic [ADDR_W-1:0] post_rem;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_cnt;
  logic              rd_phase;
  logic              wr_en;
  logic              hit;

  assign wr_en = (state == PRE) || (state == ARMED) || (state == POST);
  assign hit   = ((probe ^ value_l) & mask_l) == '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= probe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wp          <= '0;
      pre_l       <= '0;
      mask_l      <= '0;
      value_l     <= '0;
      pre_rem     <= '0;
      post_rem    <= '0;
      trig_addr   <= '0;
      rd_addr     <= '0;
      rd_cnt      <= '0;
      rd_phase    <= 1'b0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
      done        <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        triggered   <= 1'b0;
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              pre_l   <= pre_cnt;
              mask_l  <= trig_mask;
              value_l <= trig_value;
              pre_rem <= pre_cnt;
              wp      <= '0;
              busy    <= 1'b1;
              state   <= (pre_cnt != '0) ? PRE : ARMED;
            end
          end
          PRE: begin
            wp      <= wp + A_ONE;
            pre_rem <= pre_rem - A_ONE;
            if (pre_rem == A_ONE) state <= ARMED;
          end
          ARMED: begin
            wp <= wp + A_ONE;
            if (hit) begin
              trig_addr <= wp;
              triggered <= 1'b1;
              post_rem  <= ~pre_l;  // DEPTH-1-pre_l
              rd_phase  <= 1'b0;
              rd_cnt    <= '0;
              state     <= (pre_l == A_MAX) ? READ : POST;
            end
          end
          POST: begin
            wp       <= wp + A_ONE;
            post_rem <= post_rem - A_ONE;
            if (post_rem == A_ONE) state <= READ;
          end
          READ: begin
            if (!rd_phase) begin
              // first READ cycle only issues the start address
              rd_addr  <= trig_addr - pre_l;
              rd_phase <= 1'b1;
            end else if (rd.rd_valid && rd.rd_ready && rd.rd_last) begin
              state       <= IDLE;
              busy        <= 1'b0;
              triggered   <= 1'b0;
              done        <= 1'b1;
              rd.rd_valid <= 1'b0;
              rd.rd_last  <= 1'b0;
            end else if ((!rd.rd_valid || rd.rd_ready) && (rd_cnt != CNT_FULL)) begin
              // RAM output register doubles as the stream register; its
              // read enable holds it stable while stalled
              rd.rd_data  <= mem[rd_addr];
              rd.rd_valid <= 1'b1;
              rd.rd_last  <= (rd_cnt == CNT_LAST);
              rd_addr     <= rd_addr + A_ONE;
              rd_cnt      <= rd_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_probe_capture_ctrl.sv
module tb_probe_capture_ctrl;
  localparam int DATA_W = 96;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic [ADDR_W-1:0] pre_cnt = '0;
  logic [DATA_W-1:0] trig_mask = '0;
  logic [DATA_W-1:0] trig_value = '0;
  logic [DATA_W-1:0] probe = '0;
  logic busy, triggered, done;

  probe_capture_if #(.DATA_W(DATA_W)) rif ();

  probe_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pre_cnt(pre_cnt),
    .trig_mask(trig_mask), .trig_value(trig_value), .probe(probe),
    .busy(busy), .triggered(triggered), .done(done), .rd(rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int popped = 0;
  bit rand_ready = 1'b0;
  bit done_exp = 1'b0;
  bit done_seen = 1'b0;
  logic [DATA_W:0] q[$];  // {last, data}

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done_exp) begin
      chk("done_pulse", {95'd0, done}, 96'd1);
      chk("busy_at_done", {95'd0, busy}, 96'd0);
      chk("trig_at_done", {95'd0, triggered}, 96'd0);
      done_exp  = 1'b0;
      done_seen = 1'b1;
    end else if (done) begin
      checks++; errors++;
      $display("FAIL done_spurious: got 1 expected 0 at %0t", $time);
    end
    if (rif.rd_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %0h expected none", rif.rd_data);
      end else begin
        chk("rd_data", rif.rd_data, q[0][DATA_W-1:0]);
        chk("rd_last", {95'd0, rif.rd_last}, {95'd0, q[0][DATA_W]});
        if (rif.rd_ready) begin
          if (q[0][DATA_W]) done_exp = 1'b1;
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
    probe = DATA_W'(cnt);
    rif.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_expected(input int start);
    for (int k = 0; k < DEPTH; k++) q.push_back({(k == DEPTH - 1), DATA_W'(start + k)});
  endtask

  task automatic start_capture(input int pre, input logic [DATA_W-1:0] m,
                               input logic [DATA_W-1:0] v, input int c0);
    done_seen  = 1'b0;
    cnt        = c0;
    probe      = DATA_W'(cnt);
    pre_cnt    = ADDR_W'(pre);
    trig_mask  = m;
    trig_value = v;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    // scramble config; the capture must use the latched copy
    pre_cnt    = ADDR_W'($urandom);
    trig_mask  = '0;
    trig_value = DATA_W'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000 && !done_seen; i++) tick();
    chk({name, "_done_seen"}, {95'd0, done_seen}, 96'd1);
    chk({name, "_drained"}, DATA_W'(q.size()), '0);
    chk({name, "_busy_after"}, {95'd0, busy}, 96'd0);
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 4000 && cnt != target; i++) tick();
    chk("reach_cnt", DATA_W'(cnt), DATA_W'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.rd_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", {95'd0, busy}, 96'd0);
    chk("rst_triggered", {95'd0, triggered}, 96'd0);
    chk("rst_done", {95'd0, done}, 96'd0);
    chk("rst_valid", {95'd0, rif.rd_valid}, 96'd0);
    chk("rst_last", {95'd0, rif.rd_last}, 96'd0);
    chk("rst_data", rif.rd_data, '0);
    rst = 1'b0;
    tick();

    // Case 1: counter, pre 4, trigger at 100
    push_expected(96);
    start_capture(4, ONES, 100, 0);
    chk("c1_busy", {95'd0, busy}, 96'd1);
    wait_cnt(100);
    chk("c1_trig_before", {95'd0, triggered}, 96'd0);
    tick();
    chk("c1_trig_after", {95'd0, triggered}, 96'd1);
    chk("c1_no_valid_in_post", {95'd0, rif.rd_valid}, 96'd0);
    wait_done("c1");

    // Case 2: mask 0, pre 0, first ARMED sample is 10
    push_expected(10);
    start_capture(0, '0, 0, 9);
    wait_done("c2");

    // Case 3: pre 8, trigger at 1000 (history wraps many times)
    push_expected(992);
    start_capture(8, ONES, 1000, 0);
    wait_done("c3");

    // Case 4: max pre_cnt, trigger sample is the last word
    push_expected(245);
    start_capture(255, ONES, 500, 0);
    wait_done("c4");

    // Case 5: Case 1 under random backpressure
    push_expected(96);
    start_capture(4, ONES, 100, 0);
    rand_ready = 1'b1;
    wait_done("c5");
    rand_ready = 1'b0;

    // Case 6a: arm while busy is ignored
    push_expected(296);
    start_capture(4, ONES, 300, 0);
    for (int i = 0; i < 10; i++) tick();
    pre_cnt = '0; trig_mask = '0; trig_value = '0; arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done("c6a");

    // Case 6b: abort in ARMED, arm+abort in IDLE, then re-arm
    start_capture(4, ONES, 5000, 0);
    for (int i = 0; i < 30; i++) tick();
    abort = 1'b1; arm = 1'b1;
    tick();
    chk("abort_busy", {95'd0, busy}, 96'd0);
    chk("abort_trig", {95'd0, triggered}, 96'd0);
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("abort_arm_ignored", {95'd0, busy}, 96'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_done", {95'd0, done_seen}, 96'd0);
    push_expected(48);
    start_capture(2, ONES, 50, 0);
    wait_done("c6b");

    // Case 6c: reset during READ after 20 words
    push_expected(96);
    start_capture(4, ONES, 100, 0);
    begin
      int p0;
      p0 = popped;
      for (int i = 0; i < 4000 && popped < p0 + 20; i++) tick();
      chk("c6c_words_before_rst", DATA_W'(popped >= p0 + 20), DATA_W'(1));
    end
    rst = 1'b1;
    tick();
    q.delete();
    done_exp = 1'b0;
    tick();
    rst = 1'b0;
    chk("c6c_busy", {95'd0, busy}, 96'd0);
    chk("c6c_valid", {95'd0, rif.rd_valid}, 96'd0);
    chk("c6c_trig", {95'd0, triggered}, 96'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("c6c_no_done", {95'd0, done_seen}, 96'd0);

    // recovery after reset
    push_expected(10);
    start_capture(0, '0, 0, 9);
    wait_done("c6c_recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
